round_sequencer: RTL and testbench

//  Game-round controller for the LED target datapath. It issues single-cycle freq

---
 rtl/game_pkg.sv | 31 +++
 rtl/sat_cnt8.sv | 26 ++
 rtl/round_sequencer.sv | 159 +++++++++++++++
 tb/tb_round_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the LED target game: FSM state encoding,
// default timing constants and small elaboration-time helpers.
package game_pkg;

    // Width of the LED / button buses
    localparam int LED_W = 8;

    // Default timing, in clk cycles at 100 MHz
    localparam int DEF_WIN_INIT = 100_000_000;
    localparam int DEF_WIN_MIN  = 25_000_000;
    localparam int DEF_WIN_STEP = 5_000_000;
    localparam int DEF_GAP_CYC  = 25_000_000;
    localparam int DEF_ROUNDS   = 32;
    localparam int DEF_CNT_W    = 27;

    // Round sequencer states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPAWN  = 3'd1,
        S_SETTLE = 3'd2,
        S_SHOW   = 3'd3,
        S_GAP    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Larger of two integers, used to size counters at elaboration
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit up-counter that sticks at 255 and can be cleared synchronously.
// Used for the score and miss tallies.
module sat_cnt8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    logic [7:0] count_reg;

    // Clear has priority; increments stop once the count reaches 255
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= 8'd0;
        end else if (clr) begin
            count_reg <= 8'd0;
        end else if (inc && (count_reg != 8'hFF)) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/round_sequencer.sv
// Game-round controller: spawns a target via a freq pulse, lights it for a
// shrinking reaction window, judges button hits and keeps score/misses.
module round_sequencer
    import game_pkg::*;
#(
    parameter int WIN_INIT = DEF_WIN_INIT,
    parameter int WIN_MIN  = DEF_WIN_MIN,
    parameter int WIN_STEP = DEF_WIN_STEP,
    parameter int GAP_CYC  = DEF_GAP_CYC,
    parameter int ROUNDS   = DEF_ROUNDS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LED_W-1:0] hit,
    input  logic [LED_W-1:0] LED_num,
    output logic             freq,
    output logic             led_en,
    output logic [7:0]       score,
    output logic [7:0]       misses,
    output logic [7:0]       round_cnt,
    output logic             busy,
    output logic             done
);

    // Round counter must reach ROUNDS itself; the output shows its low 8 bits
    localparam int RC_W = max_int(8, $clog2(ROUNDS + 1));

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] window_reg;
    logic [RC_W-1:0]  rounds_reg;
    logic             freq_reg;
    logic             led_en_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             hit_any;
    logic             hit_match;
    logic             cnt_zero;
    logic             in_show;
    logic             judge;
    logic             game_start;
    logic             score_inc;
    logic             miss_inc;
    logic             last_round;
    logic [CNT_W:0]   win_diff;
    logic [CNT_W-1:0] win_shrunk;

    // A match needs a non-empty hit equal to the one-hot target
    assign hit_any    = |hit;
    assign hit_match  = hit_any && (hit == LED_num);
    assign cnt_zero   = (cnt_reg == '0);
    assign in_show    = (state_reg == S_SHOW);
    // Any button press ends the round; otherwise the window expiring does
    assign judge      = in_show && (hit_any || cnt_zero);
    assign game_start = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign score_inc  = in_show && hit_match;
    assign miss_inc   = judge && !hit_match;
    assign last_round = (rounds_reg == RC_W'(ROUNDS));

    // One extra bit catches an underflow before comparing against the floor
    assign win_diff   = {1'b0, window_reg} - (CNT_W + 1)'(WIN_STEP);
    assign win_shrunk = (win_diff[CNT_W] || (win_diff < (CNT_W + 1)'(WIN_MIN)))
                        ? CNT_W'(WIN_MIN) : win_diff[CNT_W-1:0];

    // Game FSM with window register, shared down-counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            window_reg <= CNT_W'(WIN_INIT);
            rounds_reg <= '0;
            freq_reg   <= 1'b0;
            led_en_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            freq_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        window_reg <= CNT_W'(WIN_INIT);
                        rounds_reg <= '0;
                        state_reg  <= S_SPAWN;
                        freq_reg   <= 1'b1;
                        busy_reg   <= 1'b1;
                        done_reg   <= 1'b0;
                    end
                end
                S_SPAWN: begin
                    state_reg <= S_SETTLE;
                end
                S_SETTLE: begin
                    cnt_reg    <= window_reg - CNT_W'(1);
                    state_reg  <= S_SHOW;
                    led_en_reg <= 1'b1;
                end
                S_SHOW: begin
                    if (judge) begin
                        if (hit_match) begin
                            window_reg <= win_shrunk;
                        end
                        rounds_reg <= rounds_reg + RC_W'(1);
                        cnt_reg    <= CNT_W'(GAP_CYC - 1);
                        state_reg  <= S_GAP;
                        led_en_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_zero) begin
                        if (last_round) begin
                            state_reg <= S_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_SPAWN;
                            freq_reg  <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg  <= S_IDLE;
                    led_en_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b0;
                end
            endcase
        end
    end

    sat_cnt8 u_score (
        .clk   (clk),
        .rst   (rst),
        .clr   (game_start),
        .inc   (score_inc),
        .count (score)
    );

    sat_cnt8 u_misses (
        .clk   (clk),
        .rst   (rst),
        .clr   (game_start),
        .inc   (miss_inc),
        .count (misses)
    );

    assign freq      = freq_reg;
    assign led_en    = led_en_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign round_cnt = rounds_reg[7:0];

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: a 3-round instance (a) and a
// 300-round instance (b), each fed by a small rotating randomizer model.
module tb_round_sequencer;

    logic       clk;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] hit_a, hit_b;
    logic [7:0] led_num_a, led_num_b;
    logic       freq_a, freq_b;
    logic       led_en_a, led_en_b;
    logic [7:0] score_a, score_b;
    logic [7:0] misses_a, misses_b;
    logic [7:0] round_cnt_a, round_cnt_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    int checks = 0;
    int errors = 0;

    round_sequencer #(
        .WIN_INIT(20), .WIN_MIN(8), .WIN_STEP(5), .GAP_CYC(4), .ROUNDS(3)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .hit(hit_a), .LED_num(led_num_a),
        .freq(freq_a), .led_en(led_en_a), .score(score_a), .misses(misses_a),
        .round_cnt(round_cnt_a), .busy(busy_a), .done(done_a)
    );

    round_sequencer #(
        .WIN_INIT(20), .WIN_MIN(8), .WIN_STEP(5), .GAP_CYC(4), .ROUNDS(300)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .hit(hit_b), .LED_num(led_num_b),
        .freq(freq_b), .led_en(led_en_b), .score(score_b), .misses(misses_b),
        .round_cnt(round_cnt_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Randomizer stand-ins: rotate the one-hot target one cycle after freq
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_num_a <= 8'h01;
            led_num_b <= 8'h01;
        end else begin
            if (freq_a) led_num_a <= {led_num_a[6:0], led_num_a[7]};
            if (freq_b) led_num_b <= {led_num_b[6:0], led_num_b[7]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return led_en_a;
            1:       return done_a;
            2:       return led_en_b;
            default: return done_b;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string tag);
        int n = 0;
        while (!sig_of(sel) && (n < budget)) begin
            tick();
            n++;
        end
        check(tag, 32'(sig_of(sel)), 1);
    endtask

    // mode 0: exact target, 1: neighbouring button, 2: target plus neighbour
    task automatic do_round(input bit b, input int cyc, input int mode);
        logic [7:0] led;
        logic [7:0] h;
        wait_for(b ? 2 : 0, 100, "wait_show");
        repeat (cyc - 1) tick();
        led = b ? led_num_b : led_num_a;
        case (mode)
            0:       h = led;
            1:       h = {led[6:0], led[7]};
            default: h = led | {led[6:0], led[7]};
        endcase
        if (b) hit_b = h;
        else   hit_a = h;
        tick();
        hit_a = 8'h00;
        hit_b = 8'h00;
        check("led_off_after_judge", 32'(b ? led_en_b : led_en_a), 0);
    endtask

    task automatic measure_show(input bit b, output int len);
        len = 0;
        wait_for(b ? 2 : 0, 100, "wait_show_len");
        while ((b ? led_en_b : led_en_a) && (len < 100)) begin
            len++;
            tick();
        end
    endtask

    initial begin
        int k;
        int fcount;
        int led_len;
        int len;

        rst = 1'b0; start_a = 0; start_b = 0; hit_a = 0; hit_b = 0;

        // Reset state
        repeat (3) tick();
        check("rst_freq", freq_a, 0);
        check("rst_led_en", led_en_a, 0);
        check("rst_score", score_a, 0);
        check("rst_misses", misses_a, 0);
        check("rst_round_cnt", round_cnt_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        rst = 1'b1;
        tick();
        check("idle_freq", freq_a, 0);

        // 1: no hits, three timeouts
        start_a = 1; tick(); start_a = 0;
        check("t1_freq_rise", freq_a, 1);
        check("t1_busy", busy_a, 1);
        tick();
        check("t1_freq_fall", freq_a, 0);
        check("t1_settle_led", led_en_a, 0);
        tick();
        check("t1_led_rise", led_en_a, 1);
        k = 3; fcount = 1; led_len = 1;
        while (!done_a && (k < 400)) begin
            tick(); k++;
            if (freq_a) fcount++;
            if ((fcount == 1) && led_en_a) led_len++;
        end
        check("t1_done_cycle", k, 79);
        check("t1_freq_count", fcount, 3);
        check("t1_show_len", led_len, 20);
        check("t1_misses", misses_a, 3);
        check("t1_score", score_a, 0);
        check("t1_round_cnt", round_cnt_a, 3);
        check("t1_done", done_a, 1);
        check("t1_busy_done", busy_a, 0);

        // 2: correct hit on SHOW cycle 2 every round
        start_a = 1; tick(); start_a = 0;
        check("t2_clr_misses", misses_a, 0);
        check("t2_clr_round", round_cnt_a, 0);
        check("t2_done_low", done_a, 0);
        for (int r = 0; r < 3; r++) begin
            do_round(0, 2, 0);
            check("t2_score", score_a, r + 1);
            check("t2_misses", misses_a, 0);
        end
        wait_for(1, 100, "t2_wait_done");
        check("t2_final_score", score_a, 3);
        check("t2_final_round", round_cnt_a, 3);

        // 3: wrong button, multi-button, then correct
        start_a = 1; tick(); start_a = 0;
        do_round(0, 2, 1);
        check("t3_wrong_miss", misses_a, 1);
        check("t3_wrong_score", score_a, 0);
        do_round(0, 3, 2);
        check("t3_multi_miss", misses_a, 2);
        check("t3_multi_score", score_a, 0);
        do_round(0, 2, 0);
        check("t3_ok_score", score_a, 1);
        check("t3_ok_miss", misses_a, 2);
        wait_for(1, 100, "t3_wait_done");

        // 4: hits on the last window cycle, hit in GAP ignored, window 20->15->10
        start_a = 1; tick(); start_a = 0;
        do_round(0, 20, 0);
        check("t4_last_cycle_score", score_a, 1);
        check("t4_last_cycle_miss", misses_a, 0);
        hit_a = led_num_a; tick(); hit_a = 8'h00; tick();
        check("t4_gap_score", score_a, 1);
        check("t4_gap_miss", misses_a, 0);
        check("t4_gap_round", round_cnt_a, 1);
        do_round(0, 15, 0);
        check("t4_win15_score", score_a, 2);
        measure_show(0, len);
        check("t4_window_10", len, 10);
        check("t4_timeout_miss", misses_a, 1);
        wait_for(1, 100, "t4_wait_done");
        check("t4_round_cnt", round_cnt_a, 3);

        // 5: start while busy ignored, async reset mid-SHOW
        start_a = 1; tick(); start_a = 0;
        wait_for(0, 100, "t5_wait_show");
        start_a = 1; tick(); start_a = 0;
        check("t5_busy_start_freq", freq_a, 0);
        check("t5_busy_start_led", led_en_a, 1);
        tick();
        check("t5_busy_start_led2", led_en_a, 1);
        hit_a = led_num_a; tick(); hit_a = 8'h00;
        check("t5_score", score_a, 1);
        wait_for(0, 100, "t5_wait_show2");
        tick(); tick();
        rst = 1'b0; #1;
        check("t5_rst_led", led_en_a, 0);
        check("t5_rst_score", score_a, 0);
        check("t5_rst_round", round_cnt_a, 0);
        check("t5_rst_busy", busy_a, 0);
        tick();
        rst = 1'b1;
        fcount = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (freq_a) fcount++;
        end
        check("t5_no_freq", fcount, 0);
        check("t5_idle_done", done_a, 0);
        start_a = 1; tick(); start_a = 0;
        check("t5_restart_freq", freq_a, 1);

        // Window floor: 20->15->10->8 on the 300-round instance
        start_b = 1; tick(); start_b = 0;
        for (int r = 0; r < 3; r++) do_round(1, 2, 0);
        check("clamp_score", score_b, 3);
        measure_show(1, len);
        check("clamp_window_8", len, 8);
        check("clamp_miss", misses_b, 1);
        rst = 1'b0; tick(); rst = 1'b1; tick();

        // 6: 300 correct rounds, saturation and round_cnt wrap
        start_b = 1; tick(); start_b = 0;
        for (int r = 0; r < 300; r++) begin
            do_round(1, 2, 0);
            if (r == 254) check("t6_score_255", score_b, 255);
            if (r == 255) begin
                check("t6_score_sat", score_b, 255);
                check("t6_round_wrap", round_cnt_b, 0);
            end
        end
        wait_for(3, 100, "t6_wait_done");
        check("t6_final_score", score_b, 255);
        check("t6_final_miss", misses_b, 0);
        check("t6_final_round", round_cnt_b, 44);
        check("t6_done", done_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
